// File: rtl/icmp_rx.sv
// ICMP echo-request receiver: parses the header, checks the checksum, and pulses a reply trigger.
// Optional checksum verification is built only when ICMP_CHECKSUM_CHECK_EN is defined.
module icmp_rx #(
    parameter logic [15:0] P_MIN_LEN = 16'd8,
    parameter logic [15:0] P_MAX_LEN = 16'd1480
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_icmp_data,
    input  logic        i_icmp_valid,
    input  logic        i_icmp_last,
    output logic        o_trig_reply,
    output logic [15:0] o_trig_seq,
    output logic [15:0] o_trig_id,
    output logic        o_rx_err
);

    typedef enum logic [2:0] {S_IDLE, S_RECV, S_FOLD1, S_FOLD2, S_EVAL} state_t;

    state_t      state, state_nxt;
    logic [15:0] r_cnt;
    logic [7:0]  r_type, r_code;
    logic [15:0] r_id, r_seq;
    logic        r_ovr;
    logic        accept, busy, len_bad, cksum_ok, ovr_now;
    logic [15:0] idx;

    assign accept  = i_icmp_valid && (state == S_IDLE || state == S_RECV);
    assign busy    = (state == S_FOLD1 || state == S_FOLD2 || state == S_EVAL);
    assign idx     = (state == S_IDLE) ? 16'd0 : r_cnt;
    assign len_bad = (r_cnt < P_MIN_LEN) || (r_cnt > P_MAX_LEN);
    assign ovr_now = r_ovr || i_icmp_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_icmp_valid) state_nxt = i_icmp_last ? S_FOLD1 : S_RECV;
            S_RECV:  if (i_icmp_valid && i_icmp_last) state_nxt = S_FOLD1;
            S_FOLD1: state_nxt = S_FOLD2;
            S_FOLD2: state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte counter and header capture; the overrun flag is rearmed by each frame's first byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= 16'd0;
            r_type <= 8'd0;
            r_code <= 8'd0;
            r_id   <= 16'd0;
            r_seq  <= 16'd0;
            r_ovr  <= 1'b0;
        end else begin
            if (accept) begin
                if (state == S_IDLE) begin
                    r_cnt <= 16'd1;
                    r_ovr <= 1'b0;
                end else if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
                case (idx)
                    16'd0:   r_type      <= i_icmp_data;
                    16'd1:   r_code      <= i_icmp_data;
                    16'd4:   r_id[15:8]  <= i_icmp_data;
                    16'd5:   r_id[7:0]   <= i_icmp_data;
                    16'd6:   r_seq[15:8] <= i_icmp_data;
                    16'd7:   r_seq[7:0]  <= i_icmp_data;
                    default: ;
                endcase
            end
            if (busy && i_icmp_valid) r_ovr <= 1'b1;
        end
    end

`ifdef ICMP_CHECKSUM_CHECK_EN
    logic [31:0] r_sum, sum_base;
    logic [7:0]  r_hi;

    assign sum_base = (state == S_IDLE) ? 32'd0 : r_sum;
    assign cksum_ok = (r_sum[15:0] == 16'hFFFF);

    // Big-endian 16b words; a trailing odd byte is padded with a zero low byte.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum <= 32'd0;
            r_hi  <= 8'd0;
        end else if (accept) begin
            if (!idx[0]) begin
                r_hi <= i_icmp_data;
                if (i_icmp_last) r_sum <= sum_base + {16'd0, i_icmp_data, 8'd0};
                else             r_sum <= sum_base;
            end else begin
                r_sum <= sum_base + {16'd0, r_hi, i_icmp_data};
            end
        end else if (state == S_FOLD1 || state == S_FOLD2) begin
            r_sum <= {16'd0, r_sum[31:16]} + {16'd0, r_sum[15:0]};
        end
    end
`else
    assign cksum_ok = 1'b1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_trig_reply <= 1'b0;
            o_rx_err     <= 1'b0;
            o_trig_seq   <= 16'd0;
            o_trig_id    <= 16'd0;
        end else begin
            o_trig_reply <= 1'b0;
            o_rx_err     <= 1'b0;
            if (state == S_EVAL) begin
                if (ovr_now || len_bad || !cksum_ok) begin
                    o_rx_err <= 1'b1;
                end else if (r_type == 8'd8 && r_code == 8'd0) begin
                    o_trig_reply <= 1'b1;
                    o_trig_seq   <= r_seq;
                    o_trig_id    <= r_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_icmp_rx.sv
// Directed bench for icmp_rx: echo accept, checksum/length/overrun rejects, reset, back-to-back.
module tb_icmp_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'd0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        trig, err;
    logic [15:0] seq, id;

    int errors = 0;
    int checks = 0;
    int trig_cnt = 0;
    int err_cnt = 0;
    logic [15:0] seq_log[$];
    logic [7:0]  frm [0:2047];

    icmp_rx dut (
        .i_clk(clk), .i_rst(rst), .i_icmp_data(data), .i_icmp_valid(valid),
        .i_icmp_last(last), .o_trig_reply(trig), .o_trig_seq(seq), .o_trig_id(id),
        .o_rx_err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (trig) begin
            trig_cnt++;
            seq_log.push_back(seq);
        end
        if (err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input logic [7:0] t, input logic [7:0] c, input logic [15:0] ck,
                         input logic [15:0] fid, input logic [15:0] fsq, input int len);
        for (int i = 0; i < len; i++) frm[i] = 8'h00;
        frm[0] = t;          frm[1] = c;
        frm[2] = ck[15:8];   frm[3] = ck[7:0];
        frm[4] = fid[15:8];  frm[5] = fid[7:0];
        frm[6] = fsq[15:8];  frm[7] = fsq[7:0];
    endtask

    task automatic send(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            data  = frm[i];
            valid = 1'b1;
            last  = (i == n - 1);
            tick();
            if (gaps && i != n - 1) begin
                valid = 1'b0;
                last  = 1'b0;
                tick();
            end
        end
        valid = 1'b0;
        last  = 1'b0;
        data  = 8'd0;
    endtask

    // Samples outputs after the 1st..4th edges following the last byte; no comparison here.
    task automatic observe(output logic early, output logic t, output logic e,
                           output logic [15:0] s, output logic [15:0] d, output logic late);
        early = 1'b0;
        repeat (2) begin
            tick();
            early = early | trig | err;
        end
        tick();
        t = trig; e = err; s = seq; d = id;
        tick();
        late = trig | err;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig got %b exp 0", trig); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (seq !== 16'h0) begin errors++; $display("FAIL reset_seq got %h exp 0000", seq); end
        checks++; if (id !== 16'h0) begin errors++; $display("FAIL reset_id got %h exp 0000", id); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_echo();
        logic ea, t, e, la; logic [15:0] s, d;
        build(8'd8, 8'd0, 16'hF7F9, 16'h0001, 16'h0005, 40);
        send(40, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if (ea !== 1'b0) begin errors++; $display("FAIL echo_early got %b exp 0", ea); end
        checks++; if (t !== 1'b1) begin errors++; $display("FAIL echo_trig got %b exp 1", t); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL echo_err got %b exp 0", e); end
        checks++; if (s !== 16'h0005) begin errors++; $display("FAIL echo_seq got %h exp 0005", s); end
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL echo_id got %h exp 0001", d); end
        checks++; if (la !== 1'b0) begin errors++; $display("FAIL echo_width got %b exp 0", la); end
    endtask

    task automatic test_bad_cksum();
        logic ea, t, e, la; logic [15:0] s, d;
        logic xt, xe; logic [15:0] xs, xd;
`ifdef ICMP_CHECKSUM_CHECK_EN
        xt = 1'b0; xe = 1'b1; xs = 16'h0005; xd = 16'h0001;
`else
        xt = 1'b1; xe = 1'b0; xs = 16'h0006; xd = 16'h0003;
`endif
        build(8'd8, 8'd0, 16'hF7F8, 16'h0001, 16'h0005, 40);
        send(40, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if (t !== xt) begin errors++; $display("FAIL badck_trig got %b exp %b", t, xt); end
        checks++; if (e !== xe) begin errors++; $display("FAIL badck_err got %b exp %b", e, xe); end
        checks++; if (s !== 16'h0005) begin errors++; $display("FAIL badck_seq got %h exp 0005", s); end
        build(8'd8, 8'd0, 16'h1234, 16'h0003, 16'h0006, 40);
        send(40, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if (e !== xe) begin errors++; $display("FAIL badck2_err got %b exp %b", e, xe); end
        checks++; if (s !== xs) begin errors++; $display("FAIL badck2_seq got %h exp %h", s, xs); end
        checks++; if (d !== xd) begin errors++; $display("FAIL badck2_id got %h exp %h", d, xd); end
    endtask

    task automatic test_echo_reply();
        logic ea, t, e, la; logic [15:0] s, d;
        build(8'd0, 8'd0, 16'hFFF9, 16'h0001, 16'h0005, 40);
        send(40, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if ((ea | t | e | la) !== 1'b0) begin errors++; $display("FAIL reply_ignored got %b exp 0", ea | t | e | la); end
    endtask

    task automatic test_length();
        logic ea, t, e, la; logic [15:0] s, d;
        build(8'd8, 8'd0, 16'hF7F9, 16'h0001, 16'h0005, 6);
        send(6, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if (ea !== 1'b0) begin errors++; $display("FAIL short_early got %b exp 0", ea); end
        checks++; if ({t, e} !== 2'b01) begin errors++; $display("FAIL short_err got %b exp 01", {t, e}); end
        checks++; if (la !== 1'b0) begin errors++; $display("FAIL short_width got %b exp 0", la); end
        build(8'd8, 8'd0, 16'hE5F6, 16'h0002, 16'h0007, 41);
        frm[40] = 8'h12;
        send(41, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if ({t, e} !== 2'b10) begin errors++; $display("FAIL odd_trig got %b exp 10", {t, e}); end
        checks++; if (s !== 16'h0007) begin errors++; $display("FAIL odd_seq got %h exp 0007", s); end
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL odd_id got %h exp 0002", d); end
        build(8'd8, 8'd0, 16'hF7F2, 16'h0001, 16'h000C, 8);
        send(8, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if ({t, e} !== 2'b10) begin errors++; $display("FAIL min_trig got %b exp 10", {t, e}); end
        checks++; if (s !== 16'h000C) begin errors++; $display("FAIL min_seq got %h exp 000c", s); end
        build(8'd8, 8'd0, 16'hF7F1, 16'h0001, 16'h000D, 1480);
        send(1480, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if ({t, e} !== 2'b10) begin errors++; $display("FAIL max_trig got %b exp 10", {t, e}); end
        checks++; if (s !== 16'h000D) begin errors++; $display("FAIL max_seq got %h exp 000d", s); end
        build(8'd8, 8'd0, 16'hF7F9, 16'h0001, 16'h0005, 1481);
        send(1481, 1'b0);
        observe(ea, t, e, s, d, la);
        checks++; if ({t, e} !== 2'b01) begin errors++; $display("FAIL long_err got %b exp 01", {t, e}); end
        checks++; if (s !== 16'h000D) begin errors++; $display("FAIL long_seq got %h exp 000d", s); end
    endtask

    task automatic test_overrun();
        build(8'd8, 8'd0, 16'hF7F5, 16'h0001, 16'h0009, 40);
        send(40, 1'b0);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        checks++; if ({trig, err} !== 2'b00) begin errors++; $display("FAIL ovr_early got %b exp 00", {trig, err}); end
        tick();
        checks++; if ({trig, err} !== 2'b01) begin errors++; $display("FAIL ovr_err got %b exp 01", {trig, err}); end
        tick();
        checks++; if ({trig, err} !== 2'b00) begin errors++; $display("FAIL ovr_width got %b exp 00", {trig, err}); end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        int t0, e0;
        build(8'd8, 8'd0, 16'hF7F9, 16'h0001, 16'h0005, 40);
        send(20, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (seq !== 16'h0) begin errors++; $display("FAIL rstmid_clr got %h exp 0000", seq); end
        t0 = trig_cnt; e0 = err_cnt;
        send(40, 1'b0);
        repeat (6) tick();
        checks++; if (trig_cnt - t0 !== 1) begin errors++; $display("FAIL rstmid_trigs got %0d exp 1", trig_cnt - t0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_errs got %0d exp 0", err_cnt - e0); end
        checks++; if (seq !== 16'h0005) begin errors++; $display("FAIL rstmid_seq got %h exp 0005", seq); end
    endtask

    task automatic test_back_to_back();
        logic ea, t, e, la; logic [15:0] s, d;
        int t0, e0;
        build(8'd8, 8'd0, 16'hF7F5, 16'h0001, 16'h0009, 40);
        send(40, 1'b1);
        observe(ea, t, e, s, d, la);
        checks++; if ({t, e} !== 2'b10) begin errors++; $display("FAIL gaps_trig got %b exp 10", {t, e}); end
        checks++; if (s !== 16'h0009) begin errors++; $display("FAIL gaps_seq got %h exp 0009", s); end
        seq_log.delete();
        t0 = trig_cnt; e0 = err_cnt;
        build(8'd8, 8'd0, 16'hF7F4, 16'h0001, 16'h000A, 40);
        send(40, 1'b0);
        repeat (3) tick();
        build(8'd8, 8'd0, 16'hF7F3, 16'h0001, 16'h000B, 40);
        send(40, 1'b0);
        repeat (6) tick();
        checks++; if (trig_cnt - t0 !== 2) begin errors++; $display("FAIL b2b_trigs got %0d exp 2", trig_cnt - t0); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_errs got %0d exp 0", err_cnt - e0); end
        if (seq_log.size() == 2) begin
            checks++; if (seq_log[0] !== 16'h000A) begin errors++; $display("FAIL b2b_seq0 got %h exp 000a", seq_log[0]); end
            checks++; if (seq_log[1] !== 16'h000B) begin errors++; $display("FAIL b2b_seq1 got %h exp 000b", seq_log[1]); end
        end else begin
            checks++; errors++;
            $display("FAIL b2b_log got %0d entries exp 2", seq_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_bad_cksum();
        test_echo_reply();
        test_length();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
